// File: rtl/car_sim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : car_sim_pkg
// Description : Shared constants and types for the car-simulator keypad path:
//               key index map, keypad event types and the queued event record.
// Revision    : 1.0 - initial release
// ============================================================================
package car_sim_pkg;

    // Number of keypad pins on the front panel
    localparam int NUM_KEYS = 12;

    // Key index map (bit positions in key_raw / key_level)
    localparam int KEY_IDX_1     = 0;
    localparam int KEY_IDX_2     = 1;
    localparam int KEY_IDX_3     = 2;
    localparam int KEY_IDX_4     = 3;
    localparam int KEY_IDX_5     = 4;
    localparam int KEY_IDX_6     = 5;
    localparam int KEY_IDX_7     = 6;
    localparam int KEY_IDX_8     = 7;
    localparam int KEY_IDX_9     = 8;
    localparam int KEY_IDX_STAR  = 9;
    localparam int KEY_IDX_0     = 10;
    localparam int KEY_IDX_SHARP = 11;

    // Event type carried by the queue
    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_UNUSED  = 2'd3
    } evt_type_e;

    // One queued keypad event
    typedef struct packed {
        logic [3:0] code;
        evt_type_e  kind;
    } evt_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Single-key conditioner: two-flop synchroniser, tick-based
//               debounce, hold counter and one-cycle press/release/long pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DB_TICKS   = 4,
    parameter int LONG_TICKS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_scan,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);
    import car_sim_pkg::*;

    localparam int DB_W = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam int HC_W = $clog2(LONG_TICKS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_TICKS - 1);
    localparam logic [HC_W-1:0] HC_MAX  = HC_W'(LONG_TICKS);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(LONG_TICKS - 1);

    logic [1:0]      sync_q;
    logic            sync;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic [HC_W-1:0] hold_cnt;
    logic            accept;

    assign sync      = sync_q[1];
    assign key_level = stable;

    // The synchronised value wins only on the tick that completes the run
    assign accept = (sync != stable) && tick_scan && (db_cnt == DB_LAST);

    // Two-flop synchroniser for the asynchronous keypad pin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    // Debounce: count ticks of disagreement, any agreement restarts the run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (sync == stable) begin
            db_cnt <= '0;
        end else if (tick_scan) begin
            if (db_cnt == DB_LAST) begin
                stable <= sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Hold counter: runs while pressed, saturates so long fires only once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (!stable) begin
            hold_cnt <= '0;
        end else if (tick_scan && (hold_cnt != HC_MAX)) begin
            hold_cnt <= hold_cnt + HC_W'(1);
        end
    end

    // Registered pulses aligned with the level change / hold threshold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= accept && sync;
            key_release <= accept && !sync;
            key_long    <= stable && tick_scan && (hold_cnt == HC_LAST);
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_conditioner
// Description : Keypad input stage: per-key debounce, per-key pending event
//               bits, fixed-priority arbiter and a show-ahead event queue.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_conditioner #(
    parameter int NUM_KEYS   = car_sim_pkg::NUM_KEYS,
    parameter int DB_TICKS   = 4,
    parameter int LONG_TICKS = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_scan,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [3:0]          evt_code,
    output logic [1:0]          evt_type,
    output logic                evt_overflow
);
    import car_sim_pkg::*;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] press_pend, release_pend, long_pend;
    logic [NUM_KEYS-1:0] clr_press, clr_release, clr_long;
    logic [NUM_KEYS-1:0] sel_mask;
    logic                found;
    logic                push;
    logic [3:0]          sel_code;
    evt_type_e           sel_type;
    logic                lost;

    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    evt_t                mem [FIFO_DEPTH];
    evt_t                head;
    logic                empty, full, pop, can_accept;

    // One conditioner per key
    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_key
            key_debounce #(
                .DB_TICKS   (DB_TICKS),
                .LONG_TICKS (LONG_TICKS)
            ) u_key_debounce (
                .clk         (clk),
                .rst         (rst),
                .tick_scan   (tick_scan),
                .key_raw     (key_raw[g]),
                .key_level   (key_level[g]),
                .key_press   (key_press[g]),
                .key_release (key_release[g]),
                .key_long    (key_long[g])
            );
        end
    endgenerate

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign pop        = !empty && evt_ready;
    // A full queue still takes a push when the head leaves on the same edge
    assign can_accept = !full || pop;

    // Arbiter: lowest key index first, then release > press > long
    always_comb begin
        found       = 1'b0;
        sel_mask    = '0;
        sel_code    = 4'd0;
        sel_type    = EVT_PRESS;
        clr_press   = '0;
        clr_release = '0;
        clr_long    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!found && (press_pend[i] || release_pend[i] || long_pend[i])) begin
                found       = 1'b1;
                sel_mask[i] = 1'b1;
                sel_code    = 4'(i);
                if (release_pend[i]) begin
                    sel_type = EVT_RELEASE;
                end else if (press_pend[i]) begin
                    sel_type = EVT_PRESS;
                end else begin
                    sel_type = EVT_LONG;
                end
            end
        end
        push = found && can_accept;
        if (push) begin
            case (sel_type)
                EVT_RELEASE: clr_release = sel_mask;
                EVT_PRESS:   clr_press   = sel_mask;
                default:     clr_long    = sel_mask;
            endcase
        end
    end

    // A pulse landing on a still-pending bit of the same type is dropped
    assign lost = |((key_press   & press_pend   & ~clr_press)   |
                    (key_release & release_pend & ~clr_release) |
                    (key_long    & long_pend    & ~clr_long));

    // Pending bits and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_pend   <= '0;
            release_pend <= '0;
            long_pend    <= '0;
            evt_overflow <= 1'b0;
        end else begin
            press_pend   <= (press_pend   & ~clr_press)   | key_press;
            release_pend <= (release_pend & ~clr_release) | key_release;
            long_pend    <= (long_pend    & ~clr_long)    | key_long;
            evt_overflow <= evt_overflow | lost;
        end
    end

    // Event queue storage and pointers; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{code: sel_code, kind: sel_type};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Show-ahead head; fields forced to zero while the queue is empty
    assign head      = mem[rd_ptr];
    assign evt_valid = !empty;
    assign evt_code  = empty ? 4'd0 : head.code;
    assign evt_type  = empty ? 2'd0 : head.kind;

endmodule
`default_nettype wire

// File: tb/tb_keypad_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_conditioner
// Description : Directed self-checking bench for keypad_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_conditioner;
    import car_sim_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_scan = 1'b0;
    logic [11:0] key_raw = '0;
    logic [11:0] key_level, key_press, key_release, key_long;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [3:0]  evt_code;
    logic [1:0]  evt_type;
    logic        evt_overflow;

    keypad_conditioner #(
        .NUM_KEYS   (12),
        .DB_TICKS   (4),
        .LONG_TICKS (200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_scan    (tick_scan),
        .key_raw      (key_raw),
        .key_level    (key_level),
        .key_press    (key_press),
        .key_release  (key_release),
        .key_long     (key_long),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_type     (evt_type),
        .evt_overflow (evt_overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Time base: one tick every 4 clocks, changed just after the rising edge
    int tcnt = 0;
    always @(posedge clk) begin
        #1;
        tcnt      = tcnt + 1;
        tick_scan = ((tcnt % 4) == 0);
    end

    // Consumer log and monitors, sampled on the falling edge
    logic [3:0] log_code[$];
    logic [1:0] log_type[$];
    int         long9_cnt = 0;
    bit         glitch_hit = 0;
    bit         valid_hit  = 0;
    always @(negedge clk) begin
        if (rst && evt_valid && evt_ready) begin
            log_code.push_back(evt_code);
            log_type.push_back(evt_type);
        end
        long9_cnt = long9_cnt + int'(key_long[9]);
        if (key_level[3] || key_press[3]) glitch_hit = 1;
        if (evt_valid) valid_hit = 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_code.delete();
        log_type.delete();
    endtask

    function automatic int log_c(input int i);
        return (i < log_code.size()) ? int'(log_code[i]) : 99;
    endfunction

    function automatic int log_t(input int i);
        return (i < log_type.size()) ? int'(log_type[i]) : 99;
    endfunction

    typedef struct {
        logic [11:0] keys;
        int          exp_first;
        int          exp_n;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int e, tk;
        bit done;

        vecs[0] = '{12'h001, 0, 1};
        vecs[1] = '{12'h800, 11, 1};
        vecs[2] = '{12'h0A0, 5, 2};
        vecs[3] = '{12'h400, 10, 1};
        vecs[4] = '{12'hFFF, 0, 12};

        // Reset state
        #1;
        check("reset_level", int'(key_level), 0);
        check("reset_valid", int'(evt_valid), 0);
        check("reset_ovf",   int'(evt_overflow), 0);
        step(3);
        rst = 1'b1;
        step(4);

        // Table: simultaneous presses drained with evt_ready high
        evt_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            clear_log();
            key_raw = vecs[v].keys;
            step(40);
            check($sformatf("tbl%0d_level", v), int'(key_level), int'(vecs[v].keys));
            check($sformatf("tbl%0d_npress", v), log_code.size(), vecs[v].exp_n);
            check($sformatf("tbl%0d_first", v), log_c(0), vecs[v].exp_first);
            check($sformatf("tbl%0d_ftype", v), log_t(0), int'(EVT_PRESS));
            key_raw = '0;
            step(40);
            check($sformatf("tbl%0d_ntotal", v), log_code.size(), 2 * vecs[v].exp_n);
            check($sformatf("tbl%0d_lvl0", v), int'(key_level), 0);
        end

        // Clean press on KEY_0 with latency tracking (sync + 4 ticks + 1)
        evt_ready = 1'b0;
        key_raw[KEY_IDX_0] = 1'b1;
        e = 0; tk = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            e = e + 1;
            if (e >= 3 && tick_scan) tk = tk + 1;
            #1;
            if (tk == 3 && !key_level[10] && !done) begin
                // still low just before the accepting tick
            end
            if (tk == 3) check("clean_early", int'(key_level[10]), 0);
            if (tk == 4) done = 1;
        end
        check("clean_timeout", int'(done), 1);
        check("clean_level", int'(key_level[10]), 1);
        check("clean_press", int'(key_press[10]), 1);
        step(1);
        check("clean_press_w", int'(key_press[10]), 0);
        check("clean_valid_1", int'(evt_valid), 0);
        step(1);
        check("clean_valid_2", int'(evt_valid), 1);
        check("clean_code", int'(evt_code), 10);
        check("clean_type", int'(evt_type), int'(EVT_PRESS));
        evt_ready = 1'b1;
        key_raw = '0;
        step(40);
        clear_log();

        // Glitch rejection: 3 ticks high on key 3
        glitch_hit = 0;
        valid_hit  = 0;
        key_raw[3] = 1'b1;
        step(12);
        key_raw[3] = 1'b0;
        step(40);
        check("glitch_level", int'(glitch_hit), 0);
        check("glitch_valid", int'(valid_hit), 0);

        // Long press and release on KEY_STAR
        clear_log();
        long9_cnt = 0;
        key_raw[9] = 1'b1;
        step(205 * 4);
        key_raw[9] = 1'b0;
        step(40);
        check("long_n",     log_code.size(), 3);
        check("long_c0",    log_c(0), 9);
        check("long_t0",    log_t(0), int'(EVT_PRESS));
        check("long_c1",    log_c(1), 9);
        check("long_t1",    log_t(1), int'(EVT_LONG));
        check("long_c2",    log_c(2), 9);
        check("long_t2",    log_t(2), int'(EVT_RELEASE));
        check("long_pulses", long9_cnt, 1);

        // Simultaneous keys under backpressure
        clear_log();
        evt_ready = 1'b0;
        key_raw = 12'h824;
        step(40);
        check("bp_valid", int'(evt_valid), 1);
        check("bp_head",  int'(evt_code), 2);
        evt_ready = 1'b1;
        step(10);
        check("bp_n",  log_code.size(), 3);
        check("bp_c0", log_c(0), 2);
        check("bp_c1", log_c(1), 5);
        check("bp_c2", log_c(2), 11);
        check("bp_t",  log_t(0) + log_t(1) + log_t(2), 0);
        check("bp_ovf", int'(evt_overflow), 0);
        key_raw = '0;
        step(40);
        clear_log();

        // Overflow: fill the queue, then repeat a press on key 0
        evt_ready = 1'b0;
        key_raw = 12'h012;
        step(40);
        key_raw = '0;
        step(40);
        check("ovf_full_ovf", int'(evt_overflow), 0);
        key_raw[0] = 1'b1;
        step(40);
        key_raw[0] = 1'b0;
        step(40);
        check("ovf_before", int'(evt_overflow), 0);
        key_raw[0] = 1'b1;
        step(40);
        check("ovf_set",  int'(evt_overflow), 1);
        check("ovf_head", int'(evt_code), 1);
        key_raw = '0;

        // Reset clears the sticky flag
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        check("ovf_cleared", int'(evt_overflow), 0);
        step(40);

        // Reset mid-operation with three queued events
        key_raw = 12'h1C0;
        step(40);
        check("rst_pre_valid", int'(evt_valid), 1);
        check("rst_pre_code",  int'(evt_code), 6);
        #1;
        rst = 1'b0;
        key_raw = '0;
        #1;
        check("rst_level", int'(key_level), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_code",  int'(evt_code), 0);
        check("rst_type",  int'(evt_type), 0);
        step(3);
        rst = 1'b1;
        valid_hit = 0;
        step(60);
        check("rst_post_valid", int'(valid_hit), 0);
        key_raw[0] = 1'b1;
        step(40);
        check("rst_new_valid", int'(evt_valid), 1);
        check("rst_new_code",  int'(evt_code), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
